// File: rtl/digital_clk_pkg.sv
// Shared types and constants for the digital clock time-setting controller.
package digital_clk_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] MAX_SECONDS = 6'd59;
    localparam logic [MIN_W-1:0] MAX_MINUTES = 6'd59;
    localparam logic [HR_W-1:0]  MAX_HOURS   = 5'd23;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_S  = 3'd3,
        COMMIT = 3'd4
    } state_t;

    localparam logic [1:0] SEL_NONE    = 2'd0;
    localparam logic [1:0] SEL_HOURS   = 2'd1;
    localparam logic [1:0] SEL_MINUTES = 2'd2;
    localparam logic [1:0] SEL_SECONDS = 2'd3;

    // Field selected for display blinking while a given state is active.
    function automatic logic [1:0] sel_for_state(input state_t st);
        case (st)
            SET_H:   return SEL_HOURS;
            SET_M:   return SEL_MINUTES;
            SET_S:   return SEL_SECONDS;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted 0->1 transition.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles that disagree with the accepted level; any
    // agreeing cycle (a bounce) restarts the count.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and press pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-keeping tick generator and set-mode controller for the digital clock.
// The prescaler doubles as the 1 Hz tick source in RUN and the 2 Hz blink
// timer while a field is being edited.
module clock_set_ctrl
    import digital_clk_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic [SEC_W-1:0] cur_seconds,
    input  logic [MIN_W-1:0] cur_minutes,
    input  logic [HR_W-1:0]  cur_hours,
    output logic             tick_1hz,
    output logic             load,
    output logic [SEC_W-1:0] load_seconds,
    output logic [MIN_W-1:0] load_minutes,
    output logic [HR_W-1:0]  load_hours,
    output logic [1:0]       edit_sel,
    output logic             blink_on
);

    localparam int PRE_W = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_TICK_MAX  = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_BLINK_MAX = PRE_W'(CLK_HZ / 4 - 1);

    logic mode_press;
    logic inc_press;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             load_q, load_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [HR_W-1:0]  hr_q, hr_d;
    logic [1:0]       edit_sel_q, edit_sel_d;
    logic             blink_q, blink_d;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_db (
        .clk     (clk_50MHz),
        .reset   (reset),
        .btn_raw (btn_mode),
        .press   (mode_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_inc_db (
        .clk     (clk_50MHz),
        .reset   (reset),
        .btn_raw (btn_inc),
        .press   (inc_press)
    );

    // Next-state, prescaler, edit-register and registered-output logic.
    // Mode has priority over inc; a mode press in RUN also suppresses the tick.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        blink_d = blink_q;

        case (state_q)
            RUN: begin
                blink_d = 1'b1;
                if (mode_press) begin
                    state_d = SET_H;
                    sec_d   = cur_seconds;
                    min_d   = cur_minutes;
                    hr_d    = cur_hours;
                    pre_d   = '0;
                end else if (pre_q == PRE_TICK_MAX) begin
                    pre_d = '0;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            SET_H, SET_M, SET_S: begin
                if (pre_q == PRE_BLINK_MAX) begin
                    pre_d   = '0;
                    blink_d = ~blink_q;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
                if (mode_press) begin
                    case (state_q)
                        SET_H:   state_d = SET_M;
                        SET_M:   state_d = SET_S;
                        default: state_d = COMMIT;
                    endcase
                end else if (inc_press) begin
                    case (state_q)
                        SET_H:   hr_d  = (hr_q == MAX_HOURS)   ? '0 : hr_q + 1'b1;
                        SET_M:   min_d = (min_q == MAX_MINUTES) ? '0 : min_q + 1'b1;
                        default: sec_d = '0;
                    endcase
                end
                if (state_d == COMMIT) begin
                    blink_d = 1'b1;
                end
            end
            COMMIT: begin
                state_d = RUN;
                pre_d   = '0;
                blink_d = 1'b1;
            end
            default: begin
                state_d = RUN;
                pre_d   = '0;
                blink_d = 1'b1;
            end
        endcase

        tick_d     = (state_d == RUN) && (pre_d == PRE_TICK_MAX);
        load_d     = (state_d == COMMIT);
        edit_sel_d = sel_for_state(state_d);
    end

    // State, prescaler, edit registers and output registers.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_q    <= RUN;
            pre_q      <= '0;
            tick_q     <= 1'b0;
            load_q     <= 1'b0;
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            edit_sel_q <= SEL_NONE;
            blink_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            load_q     <= load_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            edit_sel_q <= edit_sel_d;
            blink_q    <= blink_d;
        end
    end

    assign tick_1hz     = tick_q;
    assign load         = load_q;
    assign load_seconds = sec_q;
    assign load_minutes = min_q;
    assign load_hours   = hr_q;
    assign edit_sel     = edit_sel_q;
    assign blink_on     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with a short tick period and debounce.
module tb_clock_set_ctrl;

    localparam int CLK_HZ = 20;
    localparam int DEB    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] cur_seconds = '0;
    logic [5:0] cur_minutes = '0;
    logic [4:0] cur_hours = '0;
    logic       tick_1hz;
    logic       load;
    logic [5:0] load_seconds;
    logic [5:0] load_minutes;
    logic [4:0] load_hours;
    logic [1:0] edit_sel;
    logic       blink_on;

    int checks = 0;
    int errors = 0;

    clock_set_ctrl #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_50MHz    (clk),
        .reset        (reset),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .cur_seconds  (cur_seconds),
        .cur_minutes  (cur_minutes),
        .cur_hours    (cur_hours),
        .tick_1hz     (tick_1hz),
        .load         (load),
        .load_seconds (load_seconds),
        .load_minutes (load_minutes),
        .load_hours   (load_hours),
        .edit_sel     (edit_sel),
        .blink_on     (blink_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic m;
        logic i;
        int   ch;
        int   cm;
        int   cs;
        int   sel;
        int   ld;
        int   h;
        int   mi;
        int   s;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic m, input logic i, input int ch, input int cm,
                                input int cs, input int sel, input int ld, input int h,
                                input int mi, input int s);
        vec_t v;
        v.m = m; v.i = i; v.ch = ch; v.cm = cm; v.cs = cs;
        v.sel = sel; v.ld = ld; v.h = h; v.mi = mi; v.s = s;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raise the requested buttons and wait until the press has acted:
    // 7 cycles to the press pulse plus one for the state update.
    task automatic do_press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        repeat (8) step();
    endtask

    initial begin
        int found;

        // cur fields: h, m, s; expectations: edit_sel, load, load_h/m/s
        tbl[0]  = mk(1'b0, 1'b1, 23, 59, 45, 0, 0, 0, 0, 0);    // inc ignored in RUN
        tbl[1]  = mk(1'b1, 1'b0, 23, 59, 45, 1, 0, 23, 59, 45); // capture
        tbl[2]  = mk(1'b0, 1'b1, 23, 59, 45, 1, 0, 0, 59, 45);  // 23 -> 0
        tbl[3]  = mk(1'b0, 1'b1, 23, 59, 45, 1, 0, 1, 59, 45);
        tbl[4]  = mk(1'b1, 1'b0, 23, 59, 45, 2, 0, 1, 59, 45);
        tbl[5]  = mk(1'b0, 1'b1, 23, 59, 45, 2, 0, 1, 0, 45);   // 59 -> 0
        tbl[6]  = mk(1'b1, 1'b0, 23, 59, 45, 3, 0, 1, 0, 45);
        tbl[7]  = mk(1'b0, 1'b1, 23, 59, 45, 3, 0, 1, 0, 0);    // seconds cleared
        tbl[8]  = mk(1'b1, 1'b0, 23, 59, 45, 0, 1, 1, 0, 0);    // commit
        tbl[9]  = mk(1'b1, 1'b0, 12, 10, 30, 1, 0, 12, 10, 30);
        tbl[10] = mk(1'b1, 1'b0, 12, 10, 30, 2, 0, 12, 10, 30);
        tbl[11] = mk(1'b1, 1'b1, 12, 10, 30, 3, 0, 12, 10, 30); // mode wins

        // Reset values
        repeat (3) step();
        chk("rst_tick", tick_1hz, 0);
        chk("rst_load", load, 0);
        chk("rst_load_s", load_seconds, 0);
        chk("rst_load_m", load_minutes, 0);
        chk("rst_load_h", load_hours, 0);
        chk("rst_edit_sel", edit_sel, 0);
        chk("rst_blink", blink_on, 1);

        // Free run: this cycle is cycle 0 after reset
        reset = 1'b0;
        for (int n = 0; n < 100; n++) begin
            chk($sformatf("run_tick_c%0d", n), tick_1hz, (n % CLK_HZ == CLK_HZ - 1) ? 1 : 0);
            chk("run_load", load, 0);
            chk("run_blink", blink_on, 1);
            step();
        end

        // Bouncing mode button: 1,0,1 then hold
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
        btn_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bounce_sel_c%0d", k), edit_sel, 0);
            step();
        end
        chk("bounce_sel_enter", edit_sel, 1);
        btn_mode = 1'b0;

        // Idle in SET_H: blink toggles every CLK_HZ/4 cycles, no ticks
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("blink_c%0d", k), blink_on, ((k / (CLK_HZ / 4)) % 2 == 0) ? 1 : 0);
            chk("seth_tick", tick_1hz, 0);
            chk("seth_sel", edit_sel, 1);
            step();
        end

        reset = 1'b1;
        step();
        reset = 1'b0;

        // Edit sequences
        for (int r = 0; r < 12; r++) begin
            cur_hours   = 5'(tbl[r].ch);
            cur_minutes = 6'(tbl[r].cm);
            cur_seconds = 6'(tbl[r].cs);
            do_press(tbl[r].m, tbl[r].i);
            chk($sformatf("vec%0d_sel", r), edit_sel, tbl[r].sel);
            chk($sformatf("vec%0d_load", r), load, tbl[r].ld);
            chk($sformatf("vec%0d_h", r), load_hours, tbl[r].h);
            chk($sformatf("vec%0d_m", r), load_minutes, tbl[r].mi);
            chk($sformatf("vec%0d_s", r), load_seconds, tbl[r].s);
            btn_mode = 1'b0;
            btn_inc  = 1'b0;
            if (tbl[r].ld != 0) begin
                found = -1;
                for (int k = 1; k <= 25; k++) begin
                    step();
                    if (k == 1) begin
                        chk("post_commit_load", load, 0);
                        chk("post_commit_sel", edit_sel, 0);
                        chk("post_commit_blink", blink_on, 1);
                    end
                    if (tick_1hz === 1'b1 && found < 0) found = k;
                end
                chk("tick_after_load", found, CLK_HZ);
            end else begin
                repeat (10) step();
            end
        end

        // Reset while in SET_S abandons the edit
        reset = 1'b1;
        step();
        chk("midrst_sel", edit_sel, 0);
        chk("midrst_load", load, 0);
        chk("midrst_blink", blink_on, 1);
        chk("midrst_tick", tick_1hz, 0);
        reset = 1'b0;
        found = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (load !== 1'b0) found++;
        end
        chk("midrst_no_load", found, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
